// File: rtl/ysyx_23060208_lsu.sv
// Load/store unit: one EXU request at a time, run as a single-beat
// AXI4 read or write with lane steering, strobes and load extension.
//
// Ports:
//   clock, reset          rising-edge clock, async active-high reset
//   req_*                 EXU request (valid/ready, wen, size, unsigned,
//                         addr, wdata, tag)
//   rsp_*                 EXU response (valid/ready, rdata, tag, err)
//   aw*/w*/b*/ar*/r*      AXI4 master, single-beat INCR transfers
module ysyx_23060208_lsu #(
  parameter int          XLEN       = 32,
  parameter int          BUS_WIDTH  = 64,
  parameter int          ADDR_WIDTH = 32,
  parameter int          TAG_WIDTH  = 5,
  parameter logic [3:0]  AXI_ID     = 4'd0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_wen,
  input  logic [1:0]             req_size,
  input  logic                   req_unsigned,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [XLEN-1:0]        req_wdata,
  input  logic [TAG_WIDTH-1:0]   req_tag,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [XLEN-1:0]        rsp_rdata,
  output logic [TAG_WIDTH-1:0]   rsp_tag,
  output logic [1:0]             rsp_err,
  output logic                   awvalid,
  input  logic                   awready,
  output logic [ADDR_WIDTH-1:0]  awaddr,
  output logic [3:0]             awid,
  output logic [7:0]             awlen,
  output logic [2:0]             awsize,
  output logic [1:0]             awburst,
  output logic                   wvalid,
  input  logic                   wready,
  output logic [BUS_WIDTH-1:0]   wdata,
  output logic [BUS_WIDTH/8-1:0] wstrb,
  output logic                   wlast,
  input  logic                   bvalid,
  output logic                   bready,
  input  logic [1:0]             bresp,
  input  logic [3:0]             bid,
  output logic                   arvalid,
  input  logic                   arready,
  output logic [ADDR_WIDTH-1:0]  araddr,
  output logic [3:0]             arid,
  output logic [7:0]             arlen,
  output logic [2:0]             arsize,
  output logic [1:0]             arburst,
  input  logic                   rvalid,
  output logic                   rready,
  input  logic [BUS_WIDTH-1:0]   rdata,
  input  logic [1:0]             rresp,
  input  logic                   rlast,
  input  logic [3:0]             rid
);

  localparam int STRB_W = BUS_WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  localparam logic [1:0] E_OK  = 2'b00;
  localparam logic [1:0] E_MIS = 2'b01;
  localparam logic [1:0] E_BUS = 2'b10;
  localparam logic [1:0] E_ILL = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_AR, S_R, S_AWW, S_B, S_RESP
  } state_t;

  state_t                 state_q, state_d;
  logic                   aw_done_q, aw_done_d;
  logic                   w_done_q, w_done_d;
  logic [1:0]             size_q, size_d;
  logic                   uns_q, uns_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [XLEN-1:0]        wdata_q, wdata_d;
  logic [TAG_WIDTH-1:0]   tag_q, tag_d;
  logic [1:0]             err_q, err_d;
  logic [XLEN-1:0]        rdata_q, rdata_d;

  logic [OFF_W-1:0]       off_q;
  logic [2:0]             amask;
  logic                   misal;
  logic                   illegal;
  logic [BUS_WIDTH-1:0]   rsh;
  logic [63:0]            s64;
  logic [63:0]            e64;
  logic                   sb;
  logic [XLEN-1:0]        ext;
  logic [STRB_W-1:0]      strb_base;
  logic                   unused_in;

  assign off_q = addr_q[OFF_W-1:0];

  // Alignment mask over the low address bits, by access size.
  always_comb begin
    amask = 3'b000;
    unique case (req_size)
      2'd0:    amask = 3'b000;
      2'd1:    amask = 3'b001;
      2'd2:    amask = 3'b011;
      default: amask = 3'b111;
    endcase
  end

  assign misal   = |(req_addr[2:0] & amask);
  assign illegal = (req_size == 2'd3) && (XLEN == 32);

  // Load lane extraction, done at 64 bits then cut to XLEN.
  always_comb begin
    rsh = rdata >> {off_q, 3'b000};
    s64 = 64'(rsh);
    sb  = 1'b0;
    e64 = s64;
    unique case (size_q)
      2'd0: begin
        sb  = !uns_q & s64[7];
        e64 = {{56{sb}}, s64[7:0]};
      end
      2'd1: begin
        sb  = !uns_q & s64[15];
        e64 = {{48{sb}}, s64[15:0]};
      end
      2'd2: begin
        sb  = !uns_q & s64[31];
        e64 = {{32{sb}}, s64[31:0]};
      end
      default: e64 = s64;
    endcase
  end

  assign ext = e64[XLEN-1:0];

  always_comb begin
    strb_base = '0;
    unique case (size_q)
      2'd0:    strb_base = STRB_W'(8'h01);
      2'd1:    strb_base = STRB_W'(8'h03);
      2'd2:    strb_base = STRB_W'(8'h0f);
      default: strb_base = STRB_W'(8'hff);
    endcase
  end

  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    size_d    = size_q;
    uns_d     = uns_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    tag_d     = tag_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          size_d    = req_size;
          uns_d     = req_unsigned;
          addr_d    = req_addr;
          wdata_d   = req_wdata;
          tag_d     = req_tag;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          err_d     = E_OK;
          rdata_d   = '0;
          if (illegal) begin
            err_d   = E_ILL;
            state_d = S_RESP;
          end else if (misal) begin
            err_d   = E_MIS;
            state_d = S_RESP;
          end else if (req_wen) begin
            state_d = S_AWW;
          end else begin
            state_d = S_AR;
          end
        end
      end
      S_AR: begin
        if (arready) state_d = S_R;
      end
      S_R: begin
        if (rvalid) begin
          state_d = S_RESP;
          if (rresp != 2'b00) begin
            err_d   = E_BUS;
            rdata_d = '0;
          end else begin
            rdata_d = ext;
          end
        end
      end
      S_AWW: begin
        // Each channel latches its own handshake; leave once both done.
        aw_done_d = aw_done_q | awready;
        w_done_d  = w_done_q | wready;
        if (aw_done_d && w_done_d) begin
          state_d   = S_B;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      S_B: begin
        if (bvalid) begin
          state_d = S_RESP;
          if (bresp != 2'b00) err_d = E_BUS;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      tag_q     <= '0;
      err_q     <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      tag_q     <= tag_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  logic in_ar, in_aww, in_resp;
  assign in_ar   = (state_q == S_AR);
  assign in_aww  = (state_q == S_AWW);
  assign in_resp = (state_q == S_RESP);

  assign req_ready = (state_q == S_IDLE) && !reset;

  assign rsp_valid = in_resp;
  assign rsp_rdata = in_resp ? rdata_q : '0;
  assign rsp_tag   = in_resp ? tag_q : '0;
  assign rsp_err   = in_resp ? err_q : '0;

  assign arvalid = in_ar;
  assign araddr  = in_ar ? addr_q : '0;
  assign arsize  = in_ar ? {1'b0, size_q} : 3'd0;
  assign arlen   = 8'd0;
  assign arburst = 2'b01;
  assign arid    = AXI_ID;
  assign rready  = (state_q == S_R);

  assign awvalid = in_aww && !aw_done_q;
  assign awaddr  = in_aww ? addr_q : '0;
  assign awsize  = in_aww ? {1'b0, size_q} : 3'd0;
  assign awlen   = 8'd0;
  assign awburst = 2'b01;
  assign awid    = AXI_ID;

  assign wvalid = in_aww && !w_done_q;
  assign wdata  = in_aww
                ? (BUS_WIDTH'(wdata_q) << {off_q, 3'b000})
                : '0;
  assign wstrb  = in_aww ? (strb_base << off_q) : '0;
  assign wlast  = in_aww;
  assign bready = (state_q == S_B);

  // Single-beat only: rlast and the returned ids carry no information.
  assign unused_in = ^{rlast, rid, bid, e64};

endmodule

// File: tb/tb_ysyx_23060208_lsu.sv
// Table-driven bench for ysyx_23060208_lsu with a small AXI slave
// model, plus reset and mid-transaction reset sequences.
module tb_ysyx_23060208_lsu;

  localparam logic [3:0] ID = 4'h3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 0, req_ready;
  logic        req_wen = 0;
  logic [1:0]  req_size = 0;
  logic        req_unsigned = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [4:0]  req_tag = 0;
  logic        rsp_valid, rsp_ready = 0;
  logic [31:0] rsp_rdata;
  logic [4:0]  rsp_tag;
  logic [1:0]  rsp_err;
  logic        awvalid, awready = 0;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        wvalid, wready = 0;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast;
  logic        bvalid = 0, bready;
  logic [1:0]  bresp = 0;
  logic [3:0]  bid = 0;
  logic        arvalid, arready = 0;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid = 0, rready;
  logic [63:0] rdata = 0;
  logic [1:0]  rresp = 0;
  logic        rlast = 0;
  logic [3:0]  rid = 0;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  ysyx_23060208_lsu #(
    .XLEN(32), .BUS_WIDTH(64), .ADDR_WIDTH(32),
    .TAG_WIDTH(5), .AXI_ID(ID)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_wen(req_wen), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_tag(rsp_tag), .rsp_err(rsp_err),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .awid(awid), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .arid(arid), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .rresp(rresp), .rlast(rlast), .rid(rid)
  );

  // kind: 0 = no AXI traffic, 1 = read, 2 = write
  typedef struct packed {
    logic        wen;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [4:0]  tag;
    logic [63:0] rd;
    logic [1:0]  rresp;
    logic [1:0]  bresp;
    logic [3:0]  ar_dly;
    logic [3:0]  r_dly;
    logic [3:0]  aw_dly;
    logic [3:0]  w_dly;
    logic [3:0]  b_dly;
    logic [3:0]  bp;
    logic [3:0]  lat;
    logic [31:0] e_rd;
    logic [1:0]  e_err;
    logic [1:0]  kind;
    logic [63:0] e_wd;
    logic [7:0]  e_strb;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  task automatic chk(input string nm, input int idx,
                     input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%h want=%h", nm, idx, act, exp);
    end
  endtask

  task automatic clr_slave();
    arready = 0; rvalid = 0; awready = 0;
    wready = 0; bvalid = 0;
  endtask

  task automatic run(input int idx, input vec_t v);
    int ar_c = 0, r_c = 0, aw_c = 0, w_c = 0, b_c = 0;
    int aw_hi = 0, w_hi = 0, lat = 0;
    bit saw_ar = 0, saw_wr = 0, done = 0, unstable = 0;
    logic [31:0] ar_a = 0, aw_a = 0;
    logic [2:0]  ar_s = 0, aw_s = 0;
    logic [63:0] wd = 0;
    logic [7:0]  ws = 0;
    @(negedge clock);
    chk("req_ready_idle", idx, 64'(req_ready), 64'd1);
    req_valid = 1; req_wen = v.wen; req_size = v.size;
    req_unsigned = v.uns; req_addr = v.addr;
    req_wdata = v.wd; req_tag = v.tag;
    @(negedge clock);
    req_valid = 0;
    for (int k = 1; k <= 40 && !done; k++) begin
      if (rsp_valid) begin
        lat = k;
        done = 1;
        clr_slave();
      end else begin
        clr_slave();
        if (arvalid) begin
          if (!saw_ar) begin ar_a = araddr; ar_s = arsize; end
          else if (araddr !== ar_a) unstable = 1;
          saw_ar = 1;
          arready = (ar_c >= int'(v.ar_dly));
          ar_c++;
        end
        if (rready) begin
          rvalid = (r_c >= int'(v.r_dly));
          rdata = v.rd; rresp = v.rresp;
          r_c++;
        end
        if (awvalid) begin
          if (!saw_wr) begin aw_a = awaddr; aw_s = awsize; end
          else if (awaddr !== aw_a) unstable = 1;
          saw_wr = 1;
          awready = (aw_c >= int'(v.aw_dly));
          aw_c++; aw_hi++;
        end
        if (wvalid) begin
          if (w_hi == 0) begin wd = wdata; ws = wstrb; end
          else if (wdata !== wd || wstrb !== ws) unstable = 1;
          if (!wlast) unstable = 1;
          saw_wr = 1;
          wready = (w_c >= int'(v.w_dly));
          w_c++; w_hi++;
        end
        if (bready) begin
          bvalid = (b_c >= int'(v.b_dly));
          bresp = v.bresp;
          b_c++;
        end
        @(negedge clock);
      end
    end
    if (!done) begin
      chk("rsp_timeout", idx, 64'd0, 64'd1);
      return;
    end
    chk("latency", idx, 64'(lat), 64'(v.lat));
    chk("rsp_rdata", idx, 64'(rsp_rdata), 64'(v.e_rd));
    chk("rsp_tag", idx, 64'(rsp_tag), 64'(v.tag));
    chk("rsp_err", idx, 64'(rsp_err), 64'(v.e_err));
    chk("saw_read", idx, 64'(saw_ar), 64'(v.kind == 2'd1));
    chk("saw_write", idx, 64'(saw_wr), 64'(v.kind == 2'd2));
    chk("payload_stable", idx, 64'(unstable), 64'd0);
    if (v.kind == 2'd1) begin
      chk("araddr", idx, 64'(ar_a), 64'(v.addr));
      chk("arsize", idx, 64'(ar_s), 64'(v.size));
    end
    if (v.kind == 2'd2) begin
      chk("awaddr", idx, 64'(aw_a), 64'(v.addr));
      chk("awsize", idx, 64'(aw_s), 64'(v.size));
      chk("wdata", idx, wd, v.e_wd);
      chk("wstrb", idx, 64'(ws), 64'(v.e_strb));
      chk("aw_cycles", idx, 64'(aw_hi), 64'(v.aw_dly) + 64'd1);
      chk("w_cycles", idx, 64'(w_hi), 64'(v.w_dly) + 64'd1);
    end
    // Hold the response and offer a competing request meanwhile.
    for (int j = 0; j < int'(v.bp); j++) begin
      req_valid = 1; req_addr = 32'h8000_0100;
      req_wen = 0; req_size = 2'd0;
      @(negedge clock);
      chk("bp_req_ready", idx, 64'(req_ready), 64'd0);
      chk("bp_rsp_valid", idx, 64'(rsp_valid), 64'd1);
      chk("bp_rdata", idx, 64'(rsp_rdata), 64'(v.e_rd));
      chk("bp_tag", idx, 64'(rsp_tag), 64'(v.tag));
      chk("bp_err", idx, 64'(rsp_err), 64'(v.e_err));
      chk("bp_no_ar", idx, 64'(arvalid), 64'd0);
    end
    req_valid = 0;
    rsp_ready = 1;
    @(negedge clock);
    rsp_ready = 0;
    chk("rsp_drop", idx, 64'(rsp_valid), 64'd0);
    chk("req_ready_after", idx, 64'(req_ready), 64'd1);
  endtask

  initial begin
    //          wen sz  uns addr           wdata          tag
    //          rdata                  rr  br  ard rd awd wd bd bp lat
    //          e_rd           err kind e_wd                  strb
    vecs[0]  = '{1'b0, 2'd0, 1'b0, 32'h8000_0005, 32'h0, 5'd1,
      64'h0000_80FF_0000_0000, 2'd0, 2'd0, 4'd0, 4'd0, 4'd0, 4'd0,
      4'd0, 4'd0, 4'd3, 32'hFFFF_FF80, 2'b00, 2'd1, 64'h0, 8'h0};
    vecs[1]  = '{1'b1, 2'd1, 1'b0, 32'h8000_0006, 32'h1234, 5'd2,
      64'h0, 2'd0, 2'd0, 4'd0, 4'd0, 4'd2, 4'd0,
      4'd0, 4'd0, 4'd5, 32'h0, 2'b00, 2'd2,
      64'h1234_0000_0000_0000, 8'hC0};
    vecs[2]  = '{1'b0, 2'd2, 1'b0, 32'h8000_0002, 32'h0, 5'd3,
      64'h0, 2'd0, 2'd0, 4'd0, 4'd0, 4'd0, 4'd0,
      4'd0, 4'd0, 4'd1, 32'h0, 2'b01, 2'd0, 64'h0, 8'h0};
    vecs[3]  = '{1'b0, 2'd1, 1'b1, 32'h8000_0002, 32'h0, 5'd4,
      64'hFFFF_FFFF_FFFF_FFFF, 2'd2, 2'd0, 4'd0, 4'd0, 4'd0, 4'd0,
      4'd0, 4'd0, 4'd3, 32'h0, 2'b10, 2'd1, 64'h0, 8'h0};
    vecs[4]  = '{1'b0, 2'd2, 1'b0, 32'h8000_0004, 32'h0, 5'd5,
      64'hDEAD_BEEF_0000_0000, 2'd0, 2'd0, 4'd0, 4'd0, 4'd0, 4'd0,
      4'd0, 4'd5, 4'd3, 32'hDEAD_BEEF, 2'b00, 2'd1, 64'h0, 8'h0};
    vecs[5]  = '{1'b0, 2'd3, 1'b0, 32'h8000_0000, 32'h0, 5'd6,
      64'h0, 2'd0, 2'd0, 4'd0, 4'd0, 4'd0, 4'd0,
      4'd0, 4'd0, 4'd1, 32'h0, 2'b11, 2'd0, 64'h0, 8'h0};
    vecs[6]  = '{1'b0, 2'd0, 1'b1, 32'h8000_0007, 32'h0, 5'd7,
      64'hAB00_0000_0000_0000, 2'd0, 2'd0, 4'd0, 4'd0, 4'd0, 4'd0,
      4'd0, 4'd0, 4'd3, 32'h0000_00AB, 2'b00, 2'd1, 64'h0, 8'h0};
    vecs[7]  = '{1'b0, 2'd1, 1'b0, 32'h8000_0000, 32'h0, 5'd8,
      64'h0000_0000_0000_8001, 2'd0, 2'd0, 4'd0, 4'd0, 4'd0, 4'd0,
      4'd0, 4'd0, 4'd3, 32'hFFFF_8001, 2'b00, 2'd1, 64'h0, 8'h0};
    vecs[8]  = '{1'b1, 2'd0, 1'b0, 32'h8000_0003, 32'hFFFF_FF5A, 5'd9,
      64'h0, 2'd0, 2'd0, 4'd0, 4'd0, 4'd0, 4'd2,
      4'd0, 4'd0, 4'd5, 32'h0, 2'b00, 2'd2,
      64'h00FF_FFFF_5A00_0000, 8'h08};
    vecs[9]  = '{1'b1, 2'd2, 1'b0, 32'h8000_0004, 32'hCAFE_F00D, 5'd10,
      64'h0, 2'd0, 2'd2, 4'd0, 4'd0, 4'd0, 4'd0,
      4'd0, 4'd0, 4'd3, 32'h0, 2'b10, 2'd2,
      64'hCAFE_F00D_0000_0000, 8'hF0};
    vecs[10] = '{1'b1, 2'd1, 1'b0, 32'h8000_0001, 32'h5555, 5'd11,
      64'h0, 2'd0, 2'd0, 4'd0, 4'd0, 4'd0, 4'd0,
      4'd0, 4'd0, 4'd1, 32'h0, 2'b01, 2'd0, 64'h0, 8'h0};
    vecs[11] = '{1'b0, 2'd2, 1'b0, 32'h8000_0000, 32'h0, 5'd12,
      64'h1111_2222_3333_4444, 2'd0, 2'd0, 4'd1, 4'd2, 4'd0, 4'd0,
      4'd0, 4'd0, 4'd6, 32'h3333_4444, 2'b00, 2'd1, 64'h0, 8'h0};
    vecs[12] = '{1'b1, 2'd2, 1'b0, 32'h8000_0008, 32'h0BAD_F00D, 5'd13,
      64'h0, 2'd0, 2'd0, 4'd0, 4'd0, 4'd1, 4'd1,
      4'd1, 4'd0, 4'd5, 32'h0, 2'b00, 2'd2,
      64'h0000_0000_0BAD_F00D, 8'h0F};
    vecs[13] = '{1'b0, 2'd0, 1'b0, 32'h8000_0001, 32'h0, 5'd14,
      64'h0000_0000_0000_7F00, 2'd0, 2'd0, 4'd0, 4'd0, 4'd0, 4'd0,
      4'd0, 4'd2, 4'd3, 32'h0000_007F, 2'b00, 2'd1, 64'h0, 8'h0};

    // Reset values.
    @(negedge clock);
    chk("rst_req_ready", 0, 64'(req_ready), 64'd0);
    chk("rst_arvalid", 0, 64'(arvalid), 64'd0);
    chk("rst_awvalid", 0, 64'(awvalid), 64'd0);
    chk("rst_wvalid", 0, 64'(wvalid), 64'd0);
    chk("rst_rready", 0, 64'(rready), 64'd0);
    chk("rst_bready", 0, 64'(bready), 64'd0);
    chk("rst_rsp_valid", 0, 64'(rsp_valid), 64'd0);
    chk("rst_wstrb", 0, 64'(wstrb), 64'd0);
    chk("rst_araddr", 0, 64'(araddr), 64'd0);
    chk("rst_arburst", 0, 64'(arburst), 64'd1);
    chk("rst_awburst", 0, 64'(awburst), 64'd1);
    chk("rst_arid", 0, 64'(arid), 64'(ID));
    chk("rst_awid", 0, 64'(awid), 64'(ID));
    @(negedge clock);
    reset = 0;

    for (int i = 0; i < NV; i++) run(i, vecs[i]);

    // Reset while the read data channel is waiting.
    @(negedge clock);
    req_valid = 1; req_wen = 0; req_size = 2'd2;
    req_addr = 32'h8000_0010; req_tag = 5'd20;
    @(negedge clock);
    req_valid = 0;
    chk("mid_arvalid", 99, 64'(arvalid), 64'd1);
    arready = 1;
    @(negedge clock);
    arready = 0;
    chk("mid_rready", 99, 64'(rready), 64'd1);
    #2 reset = 1;
    #1;
    chk("mid_rst_rready", 99, 64'(rready), 64'd0);
    chk("mid_rst_arvalid", 99, 64'(arvalid), 64'd0);
    chk("mid_rst_awvalid", 99, 64'(awvalid), 64'd0);
    chk("mid_rst_wvalid", 99, 64'(wvalid), 64'd0);
    chk("mid_rst_bready", 99, 64'(bready), 64'd0);
    chk("mid_rst_rsp_valid", 99, 64'(rsp_valid), 64'd0);
    chk("mid_rst_req_ready", 99, 64'(req_ready), 64'd0);
    @(negedge clock);
    reset = 0;
    @(negedge clock);
    chk("post_rst_req_ready", 99, 64'(req_ready), 64'd1);
    chk("post_rst_rready", 99, 64'(rready), 64'd0);
    run(100, vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
